// File: rtl/axis_pkg.sv
// Shared types and pointer helpers for the AXI-Stream packet FIFO.
// Pointers carry one extra wrap bit above the address bits.
package axis_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } fifo_wr_state_e;

    localparam int PTR_MAX_W = 32;

    // Callers truncate the result to their pointer width, so wrap is handled.
    function automatic logic [PTR_MAX_W-1:0] ptr_diff(
        input logic [PTR_MAX_W-1:0] a,
        input logic [PTR_MAX_W-1:0] b
    );
        return a - b;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port word store: synchronous write, asynchronous read.
// Read data follows the read address combinationally (FWFT).
module axis_fifo_ram #(
    parameter int WIDTH = 201,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with cut-through or store-and-forward operation,
// oversize-packet drop and occupancy / packet-count status.
module axis_pkt_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int USER_WIDTH  = 128,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 1,
    parameter int AF_THRESH   = 12
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic [USER_WIDTH-1:0]   m_axis_tuser,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  pkt_count,
    output logic                    drop_pulse
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int WW = 1 + KW + DATA_WIDTH + USER_WIDTH;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] LAST_FIT = PW'(DEPTH - 1);
    localparam logic [PW-1:0] AF_P = PW'(AF_THRESH);

    fifo_wr_state_e r_state;
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_commit_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_pkt_count;
    logic           r_drop;

    logic [PW-1:0]  w_occ;
    logic [PW-1:0]  w_uncommitted;
    logic [PW-1:0]  w_wr_nxt;
    logic           w_full;
    logic           w_wr;
    logic           w_rd;
    logic           w_store;
    logic           w_oversize;
    logic           w_commit_last;
    logic [WW-1:0]  w_wdata;
    logic [WW-1:0]  w_rdata;

    assign w_occ = PW'(ptr_diff(PTR_MAX_W'(r_wr_ptr), PTR_MAX_W'(r_rd_ptr)));
    assign w_uncommitted =
        PW'(ptr_diff(PTR_MAX_W'(r_wr_ptr), PTR_MAX_W'(r_commit_ptr)));
    assign w_full = (w_occ == DEPTH_P);

    assign s_axis_tready = !areset && ((r_state == DROP) || !w_full);
    assign m_axis_tvalid = (PACKET_MODE != 0) ? (r_commit_ptr != r_rd_ptr)
                                              : (r_wr_ptr != r_rd_ptr);

    assign w_wr  = s_axis_tvalid && s_axis_tready;
    assign w_rd  = m_axis_tvalid && m_axis_tready;
    assign w_store = w_wr && (r_state != DROP);
    assign w_commit_last = w_store && s_axis_tlast;
    // A non-last word filling every slot means this packet can never fit.
    assign w_oversize = (PACKET_MODE != 0) && w_store && !s_axis_tlast
                        && (w_uncommitted == LAST_FIT);

    always_comb begin
        w_wr_nxt = r_wr_ptr;
        if (w_oversize) begin
            w_wr_nxt = r_commit_ptr;
        end else if (w_store) begin
            w_wr_nxt = r_wr_ptr + 1'b1;
        end
    end

    assign w_wdata = {s_axis_tlast, s_axis_tkeep, s_axis_tdata, s_axis_tuser};
    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata, m_axis_tuser} = w_rdata;

    axis_fifo_ram #(
        .WIDTH (WW),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk   (aclk),
        .i_we    (w_store),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_pkt_count  <= '0;
            r_drop       <= 1'b0;
        end else begin
            r_drop   <= w_oversize;
            r_wr_ptr <= w_wr_nxt;
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (PACKET_MODE == 0) begin
                r_commit_ptr <= w_wr_nxt;
            end else if (w_commit_last) begin
                r_commit_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_commit_last && !(w_rd && m_axis_tlast)) begin
                r_pkt_count <= r_pkt_count + 1'b1;
            end else if (!w_commit_last && w_rd && m_axis_tlast) begin
                r_pkt_count <= r_pkt_count - 1'b1;
            end
            unique case (r_state)
                IDLE, WRITE: begin
                    if (w_oversize) begin
                        r_state <= DROP;
                    end else if (w_store) begin
                        r_state <= s_axis_tlast ? IDLE : WRITE;
                    end
                end
                DROP: begin
                    if (w_wr && s_axis_tlast) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign occupancy   = w_occ;
    assign almost_full = (w_occ >= AF_P);
    assign pkt_count   = r_pkt_count;
    assign drop_pulse  = r_drop;

endmodule
